// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer arbiter and its palette interface.
package sprite_pkg;

  localparam int unsigned PAL_DEPTH = 256;

  typedef logic [11:0] rgb12_t;
  typedef logic [7:0]  pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX_DFLT = 8'd0;

  function automatic rgb12_t pack_rgb(input logic [3:0] r, input logic [3:0] g,
                                      input logic [3:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Fixed-priority encoder: lowest-numbered set bit of eligible wins.
module layer_priority_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  output logic          hit,
  output logic [LW-1:0] id
);

  always_comb begin
    hit = |eligible;
    id  = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible[i]) id = LW'(i);
    end
  end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Two-stage per-pixel sprite layer arbiter feeding a shared palette lookup.
// Optional blinking layers are compiled in with SPRITE_FLASH_EN.
module sprite_layer_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_LAYERS      = 4,
  parameter pal_idx_t    TRANSPARENT_IDX = TRANSPARENT_IDX_DFLT,
  parameter int unsigned LW              = $clog2(NUM_LAYERS)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [NUM_LAYERS-1:0]   layer_hit,
  input  logic [NUM_LAYERS*8-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]   layer_en_next,
  input  logic [NUM_LAYERS-1:0]   flash_mask,
  input  logic [11:0]             bg_rgb,
  output logic [7:0]              pal_index,
  input  logic [3:0]              pal_red,
  input  logic [3:0]              pal_green,
  input  logic [3:0]              pal_blue,
  output logic [11:0]             out_rgb,
  output logic                    out_valid,
  output logic [LW-1:0]           out_layer,
  output logic                    out_hit,
  output logic [7:0]              frame_cnt
);

  logic [NUM_LAYERS-1:0] en_active;
  logic [NUM_LAYERS-1:0] flash_block;
  logic [NUM_LAYERS-1:0] eligible;
  logic                  win_hit;
  logic [LW-1:0]         win_layer;
  pal_idx_t              win_idx;

  logic                  s1_valid;
  logic                  s1_hit;
  logic [LW-1:0]         s1_layer;
  pal_idx_t              s1_idx;
  rgb12_t                bg_rgb_s1;

`ifdef SPRITE_FLASH_EN
  // Registered frame count, so blink phase only changes on a frame boundary.
  assign flash_block = flash_mask & {NUM_LAYERS{frame_cnt[3]}};
`else
  logic unused_flash_mask;
  assign unused_flash_mask = ^flash_mask;
  assign flash_block       = '0;
`endif

  // Double-buffered enables and frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      en_active <= '0;
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      en_active <= layer_en_next;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      eligible[i] = layer_hit[i] & en_active[i] & ~flash_block[i] &
                    (layer_idx[8*i +: 8] != TRANSPARENT_IDX);
    end
  end

  layer_priority_enc #(
    .N  (NUM_LAYERS),
    .LW (LW)
  ) u_prio (
    .eligible (eligible),
    .hit      (win_hit),
    .id       (win_layer)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (win_layer == LW'(i)) win_idx = layer_idx[8*i +: 8];
    end
  end

  // Stage 1: winner selection; payload holds across bubbles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_layer  <= '0;
      s1_idx    <= '0;
      bg_rgb_s1 <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_hit    <= win_hit;
        s1_layer  <= win_layer;
        s1_idx    <= win_hit ? win_idx : pal_idx_t'(0);
        bg_rgb_s1 <= bg_rgb;
      end
    end
  end

  assign pal_index = s1_idx;

  // Stage 2: capture palette response or background.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_layer <= '0;
      out_hit   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rgb   <= s1_hit ? pack_rgb(pal_red, pal_green, pal_blue) : bg_rgb_s1;
        out_layer <= s1_layer;
        out_hit   <= s1_hit;
      end
    end
  end

endmodule

// File: doc/sprite_layer_arbiter.md
Name: sprite_layer_arbiter

Overview:
- Per pixel, chooses which of NUM_LAYERS fruit/blade sprite layers drives the single shared 256-entry 12-bit palette lookup. Falls back to a background colour when no layer hits.
- Sits between the sprite ROM address generators and the VGA colour output.
- 2-stage pipeline:
  - stage 1: selects the winning layer and issues its palette index.
  - stage 2: captures the palette RGB.
- Layer enables are double-buffered per frame so gameplay logic cannot tear a frame.

Parameters:
- NUM_LAYERS, 4, number of sprite requesters; layer 0 has the highest priority.
- TRANSPARENT_IDX, 8'd0, palette index treated as see-through.
- LW, $clog2(NUM_LAYERS), width of the layer id.

Ports:
- Clk  in  1  system/pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  the current cycle carries a visible pixel.
- layer_hit  in  NUM_LAYERS  layer i covers the current pixel.
- layer_idx  in  NUM_LAYERS*8  palette index from each layer's sprite ROM; layer i occupies bits [8i+7:8i].
- layer_en_next  in  NUM_LAYERS  enable mask, loaded at the next frame_start.
- flash_mask  in  NUM_LAYERS  layers to blink; used only with SPRITE_FLASH_EN.
- bg_rgb  in  12  background colour {r,g,b}.
- pal_index  out  8  index to the shared palette lookup.
- pal_red, pal_green, pal_blue  in  4 each  palette response, combinational from pal_index.
- out_rgb  out  12  final pixel colour.
- out_valid  out  1  out_rgb is valid.
- out_layer  out  LW  winning layer id, 0 when no layer hit.
- out_hit  out  1  a layer won this pixel.
- frame_cnt  out  8  frames since reset.

Behaviour:
- Reset (asynchronous, Reset_n=0) clears all pipeline registers, en_active, and frame_cnt to 0. Reset values: pal_index=0, out_rgb=0, out_valid=0, out_layer=0, out_hit=0, frame_cnt=0.
- Reset asserted mid-frame flushes the pipeline; no partial pixel is emitted.
- Frame bookkeeping, on frame_start:
  - en_active <= layer_en_next.
  - frame_cnt <= frame_cnt + 1, wrapping 255 -> 0.
  - A pixel sampled in the same cycle as frame_start uses the old en_active.
- Eligibility: layer i is eligible when layer_hit[i] & en_active[i] & (layer_idx[i] != TRANSPARENT_IDX).
- Stage 1, registered on a cycle where pix_valid=1:
  - The lowest-numbered eligible layer wins.
  - Register s1_valid=1, s1_hit, s1_layer, and s1_idx (the winner's index, or 0 if there is no winner).
  - pal_index = s1_idx, driven directly from the register.
- Stage 2:
  - out_valid <= s1_valid.
  - out_rgb <= s1_hit ? {pal_red,pal_green,pal_blue} : bg_rgb_s1, where bg_rgb_s1 is bg_rgb registered alongside stage 1.
  - out_layer <= s1_layer; out_hit <= s1_hit.
- Latency: the pixel presented at cycle t appears at cycle t+2 (out_valid high).
- Pixel bubbles: pix_valid=0 inserts a bubble.
  - s1_valid <= 0 and out_valid follows one cycle later.
  - pal_index, out_rgb, out_layer and out_hit hold their previous values during bubbles.
- Full throughput of one pixel per cycle; there is no backpressure.
- All layers transparent or disabled: out_hit=0, out_rgb=bg_rgb, out_layer=0.
- Everything is synchronous to Clk except reset.

Optional Feature:
- Macro: SPRITE_FLASH_EN.
- When defined: a layer with flash_mask[i]=1 is additionally ineligible whenever frame_cnt[3]=1, giving a blink of 8 frames on, 8 frames off. The frame_cnt used is the registered value, so the change takes effect at the frame boundary.
- When undefined: the flash_mask port still exists but is ignored, and no extra logic is generated.

Decomposition:
- Shared package `sprite_pkg`:
  - typedef rgb12_t (12-bit {r,g,b}).
  - typedef pal_idx_t (8-bit).
  - constant PAL_DEPTH = 256.
  - default TRANSPARENT_IDX constant.
- Sub-module `layer_priority_enc`: combinational fixed-priority encoder from an eligible vector to {hit, layer id}. It is instantiated once inside the arbiter and is reusable elsewhere.

Test Plan:
- After reset, frame_start with layer_en_next=4'b1111.
  - Pixel: layer_hit=4'b0110, layer_idx[1]=8'd3, layer_idx[2]=8'd7.
  - Expect, two cycles later: pal_index was 3, out_layer=1, out_hit=1, out_rgb = palette[3].
- Transparency fallthrough: layer_idx[1]=TRANSPARENT_IDX.
  - Expect out_layer=2 and the index-7 colour.
  - With all hits transparent, expect out_hit=0 and out_rgb=bg_rgb=12'h123.
- Double buffering: change layer_en_next to 4'b0000 mid-frame.
  - Output is unchanged until frame_start.
  - From the next pixel after frame_start, out_hit=0.
  - A pixel issued in the same cycle as frame_start still uses the old mask.
- Bubbles and latency: pix_valid pattern 1,0,1,1.
  - Expect out_valid pattern 0,0,1,0,1,1; held outputs are stable during the bubble.
- Reset mid-stream: Reset_n low for 1 cycle while the pipeline is full.
  - Expect immediate out_valid=0, pal_index=0, frame_cnt=0.
  - First valid output appears 2 cycles after pixels resume.
- With SPRITE_FLASH_EN defined: flash_mask=4'b0001, layer 0 hit, 20 frame_starts.
  - Layer 0 wins in frames 0-7 and 16-19, and is suppressed in frames 8-15.
  - frame_cnt wraps 255 -> 0 after 256 pulses.
